// File: rtl/shift_add_accumulator.sv
// Shift-and-add unsigned multiplier fed LSB-first from an upstream PISO register.
// Latency: Start accepted -> LOAD (1) -> RUN (WORD_LENGTH) -> Done pulse, WORD_LENGTH+2 cycles.
// Backpressure: Start is honoured only while Ready=1; requests made while busy are dropped.
module shift_add_accumulator #(
    parameter int WORD_LENGTH = 8
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic                       Start,
    input  logic [WORD_LENGTH-1:0]     Multiplicand,
    input  logic                       Serial_Bit,
    output logic                       Shift_Enable,
    output logic                       Shift_Load,
    output logic                       Ready,
    output logic                       Done,
    output logic [2*WORD_LENGTH-1:0]   Product
);

    localparam int PW = 2 * WORD_LENGTH;
    localparam int CW = $clog2(WORD_LENGTH) + 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WORD_LENGTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [PW-1:0]          acc;
    logic [PW-1:0]          addend;
    logic [PW-1:0]          acc_sum;
    logic [CW-1:0]          bit_cnt;
    logic [WORD_LENGTH-1:0] mcand;
    logic                   last_bit;

    // The counter doubles as the weight of the multiplier bit arriving this cycle.
    assign last_bit = (bit_cnt == LAST_BIT);
    assign addend   = {{WORD_LENGTH{1'b0}}, mcand} << bit_cnt;
    assign acc_sum  = Serial_Bit ? (acc + addend) : acc;

    always_comb begin
        state_nxt    = state;
        Ready        = 1'b0;
        Done         = 1'b0;
        Shift_Enable = 1'b0;
        Shift_Load   = 1'b0;
        case (state)
            IDLE: begin
                Ready = 1'b1;
                if (Start) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                Shift_Enable = 1'b1;
                Shift_Load   = 1'b1;
                state_nxt    = RUN;
            end
            RUN: begin
                Shift_Enable = 1'b1;
                if (last_bit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                Done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state   <= IDLE;
            acc     <= '0;
            bit_cnt <= '0;
            mcand   <= '0;
            Product <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (Start) begin
                        mcand   <= Multiplicand;
                        acc     <= '0;
                        bit_cnt <= '0;
                    end
                end
                RUN: begin
                    acc     <= acc_sum;
                    bit_cnt <= bit_cnt + CW'(1);
                    // Product is published on the same edge that enters DONE.
                    if (last_bit) begin
                        Product <= acc_sum;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_add_accumulator.sv
// Bench for shift_add_accumulator with an upstream PISO register feeding the multiplier.
module tb_shift_add_accumulator;

    localparam int W = 8;

    logic           Clk = 1'b0;
    logic           Reset;
    logic           Start;
    logic [W-1:0]   Multiplicand;
    logic           Serial_Bit;
    logic           Shift_Enable;
    logic           Shift_Load;
    logic           Ready;
    logic           Done;
    logic [2*W-1:0] Product;

    logic [W-1:0]   mult_par;
    logic [W-1:0]   piso;

    int tests = 0;
    int fails = 0;

    always #5 Clk = ~Clk;

    shift_add_accumulator #(.WORD_LENGTH(W)) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Start        (Start),
        .Multiplicand (Multiplicand),
        .Serial_Bit   (Serial_Bit),
        .Shift_Enable (Shift_Enable),
        .Shift_Load   (Shift_Load),
        .Ready        (Ready),
        .Done         (Done),
        .Product      (Product)
    );

    // Upstream parallel-in serial-out register holding the multiplier.
    always @(posedge Clk) begin
        if (Shift_Enable) piso <= Shift_Load ? mult_par : {1'b0, piso[W-1:1]};
    end
    assign Serial_Bit = piso[0];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Timeline model: m_k counts cycles since the accepted Start (-1 = idle).
    int             m_k = -1;
    logic [2*W-1:0] m_a;
    logic [2*W-1:0] m_b;
    logic [2*W-1:0] m_prod = '0;
    int             m_accepts = 0;
    int             m_aborts = 0;
    int             done_seen = 0;
    bit             chk_en = 1'b0;

    always @(posedge Clk) begin
        if (Reset) begin
            if (m_k != -1) m_aborts++;
            m_k    = -1;
            m_prod = '0;
            chk_en = 1'b1;
        end else if (m_k == -1) begin
            if (Start) begin
                m_k = 1;
                m_a = {{W{1'b0}}, Multiplicand};
                m_accepts++;
            end
        end else if (m_k == W + 2) begin
            m_k = -1;
        end else begin
            if (m_k == 1) m_b = {{W{1'b0}}, mult_par};
            m_k++;
            if (m_k == W + 2) m_prod = m_a * m_b;
        end
    end

    always @(negedge Clk) begin
        if (chk_en) begin
            chk("ready",     32'(Ready),        32'(m_k == -1));
            chk("done",      32'(Done),         32'(m_k == W + 2));
            chk("shift_en",  32'(Shift_Enable), 32'(m_k >= 1 && m_k <= W + 1));
            chk("shift_ld",  32'(Shift_Load),   32'(m_k == 1));
            chk("product",   32'(Product),      32'(m_prod));
            if (Done === 1'b1) done_seen++;
        end
    end

    task automatic tick;
        @(posedge Clk);
        #2;
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2*W-1:0] exp, input string name);
        int c;
        Start        = 1'b1;
        Multiplicand = a;
        mult_par     = b;
        tick;
        Start = 1'b0;
        c     = 1;
        chk({name, "_load_c1"}, 32'(Shift_Load), 32'd1);
        while (Done !== 1'b1 && c < 40) begin
            tick;
            c++;
        end
        chk({name, "_done_cycle"}, 32'(c), 32'(W + 2));
        chk({name, "_product"}, 32'(Product), 32'(exp));
        tick;
        chk({name, "_ready_after"}, 32'(Ready), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int d1, d2, dn;
        logic [2*W-1:0] p1, p2;
        logic [W-1:0] ra, rb;

        Reset = 1'b1; Start = 1'b0; Multiplicand = '0; mult_par = '0;
        tick;
        tick;
        chk("rst_ready",   32'(Ready),        32'd1);
        chk("rst_done",    32'(Done),         32'd0);
        chk("rst_product", 32'(Product),      32'd0);
        chk("rst_shen",    32'(Shift_Enable), 32'd0);
        chk("rst_shld",    32'(Shift_Load),   32'd0);
        Reset = 1'b0;
        tick;

        run_op(8'd5,   8'd3,   16'd15,    "m5x3");
        run_op(8'd255, 8'd255, 16'd65025, "m255x255");
        run_op(8'd0,   8'd200, 16'd0,     "m0x200");
        run_op(8'd200, 8'd0,   16'd0,     "m200x0");
        run_op(8'd1,   8'd128, 16'd128,   "m1x128");

        // Start pulses during a busy operation must be dropped.
        Start = 1'b1; Multiplicand = 8'd7; mult_par = 8'd9;
        tick;
        Start = 1'b0;
        for (int c = 2; c <= 12; c++) begin
            tick;
            case (c)
                3: begin Start = 1'b1; Multiplicand = 8'd50; mult_par = 8'd77; end
                4: Start = 1'b0;
                10: begin
                    chk("busy_done_c10", 32'(Done),    32'd1);
                    chk("busy_product",  32'(Product), 32'd63);
                    Start = 1'b1; Multiplicand = 8'd99; mult_par = 8'd99;
                end
                11: begin
                    Start = 1'b0;
                    chk("busy_ready_c11", 32'(Ready), 32'd1);
                end
                12: chk("busy_no_second", 32'(Ready), 32'd1);
                default: ;
            endcase
        end

        // Reset in the middle of a RUN aborts the operation.
        Start = 1'b1; Multiplicand = 8'd100; mult_par = 8'd100;
        tick;
        Start = 1'b0;
        for (int c = 2; c <= 5; c++) tick;
        Reset = 1'b1;
        tick;
        Reset = 1'b0;
        chk("abort_product", 32'(Product),      32'd0);
        chk("abort_ready",   32'(Ready),        32'd1);
        chk("abort_shen",    32'(Shift_Enable), 32'd0);
        dn = 0;
        for (int c = 0; c < 12; c++) begin
            if (Done === 1'b1) dn++;
            tick;
        end
        chk("abort_no_done", 32'(dn), 32'd0);
        run_op(8'd12, 8'd12, 16'd144, "m12x12");

        // Start held high: back-to-back operations.
        Start = 1'b1; Multiplicand = 8'd3; mult_par = 8'd4;
        d1 = -1; d2 = -1; p1 = '0; p2 = '0;
        for (int c = 1; c <= 24; c++) begin
            tick;
            if (c == 10) begin Multiplicand = 8'd6; mult_par = 8'd7; end
            if (Done === 1'b1) begin
                if (d1 < 0) begin
                    d1 = c; p1 = Product;
                end else if (d2 < 0) begin
                    d2 = c; p2 = Product; Start = 1'b0;
                end
            end
        end
        Start = 1'b0;
        for (int c = 0; c < 20 && Ready !== 1'b1; c++) tick;
        chk("held_first_cycle", 32'(d1),      32'd10);
        chk("held_spacing",     32'(d2 - d1), 32'd11);
        chk("held_p1",          32'(p1),      32'd12);
        chk("held_p2",          32'(p2),      32'd42);
        tick;

        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            run_op(ra, rb, 16'(ra) * 16'(rb), "rnd");
        end

        tick;
        tick;
        chk("done_per_accept", 32'(done_seen), 32'(m_accepts - m_aborts));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
